// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared cache line, state and bus-width definitions
package lc3b_types;

  localparam int LC3B_ADR_WIDTH = 12;
  localparam int LC3B_SEL_WIDTH = 16;

  typedef logic [127:0]                lc3b_cache_line;
  typedef logic [LC3B_SEL_WIDTH-1:0]   lc3b_byte_sel;
  typedef logic [LC3B_ADR_WIDTH-1:0]   lc3b_line_adr;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } lc3b_cache_state;

  // Replace the bytes of old_line whose mask bit is set with the matching bytes of new_line.
  function automatic lc3b_cache_line merge_bytes(input lc3b_cache_line old_line,
                                                 input lc3b_cache_line new_line,
                                                 input lc3b_byte_sel   mask);
    lc3b_cache_line result;
    result = old_line;
    for (int i = 0; i < LC3B_SEL_WIDTH; i++) begin
      if (mask[i]) result[8*i +: 8] = new_line[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/wishbone.sv
// rtl/wishbone.sv - line-wide wishbone bus with master and slave views
interface wishbone;
  import lc3b_types::*;

  logic           cyc;
  logic           stb;
  logic           we;
  lc3b_line_adr   adr;
  lc3b_byte_sel   sel;
  lc3b_cache_line dat_m;
  lc3b_cache_line dat_s;
  logic           ack;
  logic           rty;

  modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, rty);
  modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, rty);

endinterface

// File: rtl/cache_array.sv
// rtl/cache_array.sv - per-set valid, dirty, tag and data storage
module cache_array
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int TAG_W = LC3B_ADR_WIDTH - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] index,
  input  logic             write_enable,
  input  lc3b_byte_sel     byte_mask,
  input  lc3b_cache_line   write_data,
  input  logic             fill_load,
  input  logic [TAG_W-1:0] fill_tag,
  input  lc3b_cache_line   fill_data,
  input  logic             clear_dirty,
  output logic             valid,
  output logic             dirty,
  output logic [TAG_W-1:0] tag,
  output lc3b_cache_line   line
);

  logic [NUM_SETS-1:0] valid_bits;
  logic [NUM_SETS-1:0] dirty_bits;
  logic [TAG_W-1:0]    tags  [NUM_SETS];
  lc3b_cache_line      lines [NUM_SETS];

  assign valid = valid_bits[index];
  assign dirty = dirty_bits[index];
  assign tag   = tags[index];
  assign line  = lines[index];

  // Status bits: reset wins over any fill or hit write arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill_load) begin
      valid_bits[index] <= 1'b1;
      dirty_bits[index] <= 1'b0;
    end else if (write_enable) begin
      dirty_bits[index] <= 1'b1;
    end else if (clear_dirty) begin
      dirty_bits[index] <= 1'b0;
    end
  end

  // Tag and data storage; contents are meaningless until the set is marked valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_load) begin
        tags[index]  <= fill_tag;
        lines[index] <= fill_data;
      end else if (write_enable) begin
        lines[index] <= merge_bytes(lines[index], write_data, byte_mask);
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back line cache with wishbone CPU and memory ports
module data_cache
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input logic     clk,
  input logic     reset,
  wishbone.slave  cpu_wishbone,
  wishbone.master mem_wishbone
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = LC3B_ADR_WIDTH - IDX_W;

  lc3b_cache_state  state;
  lc3b_line_adr     miss_adr;
  logic             mem_cyc;
  logic             mem_we;
  lc3b_line_adr     mem_adr;
  lc3b_cache_line   mem_dat;

  logic             request;
  logic             hit;
  logic             miss;
  logic             mem_done;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] cpu_tag;
  logic             line_valid;
  logic             line_dirty;
  logic [TAG_W-1:0] line_tag;
  lc3b_cache_line   line_data;

  assign request  = cpu_wishbone.cyc & cpu_wishbone.stb;
  assign cpu_tag  = cpu_wishbone.adr[LC3B_ADR_WIDTH-1:IDX_W];
  // Outside IDLE the array follows the latched miss, so a master that abandons its
  // request cannot redirect where the fill lands.
  assign index    = (state == IDLE) ? cpu_wishbone.adr[IDX_W-1:0] : miss_adr[IDX_W-1:0];
  assign hit      = (state == IDLE) & request & line_valid & (line_tag == cpu_tag);
  assign miss     = (state == IDLE) & request & ~hit;
  // A retry is never a completion, even if a slave raises ack alongside it.
  assign mem_done = mem_wishbone.ack & ~mem_wishbone.rty;

  assign cpu_wishbone.ack   = hit;
  assign cpu_wishbone.rty   = 1'b0;
  assign cpu_wishbone.dat_s = line_data;

  assign mem_wishbone.cyc   = mem_cyc;
  assign mem_wishbone.stb   = mem_cyc;
  assign mem_wishbone.we    = mem_we;
  assign mem_wishbone.adr   = mem_adr;
  assign mem_wishbone.sel   = '1;
  assign mem_wishbone.dat_m = mem_dat;

  cache_array #(.NUM_SETS(NUM_SETS)) u_array (
    .clk          (clk),
    .reset        (reset),
    .index        (index),
    .write_enable (hit & cpu_wishbone.we),
    .byte_mask    (cpu_wishbone.sel),
    .write_data   (cpu_wishbone.dat_m),
    .fill_load    ((state == FILL) & mem_done),
    .fill_tag     (miss_adr[LC3B_ADR_WIDTH-1:IDX_W]),
    .fill_data    (mem_wishbone.dat_s),
    .clear_dirty  ((state == WRITEBACK) & mem_done),
    .valid        (line_valid),
    .dirty        (line_dirty),
    .tag          (line_tag),
    .line         (line_data)
  );

  // Miss sequencing with registered memory-side outputs held until the slave completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mem_cyc <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            miss_adr <= cpu_wishbone.adr;
            mem_cyc  <= 1'b1;
            if (line_valid && line_dirty) begin
              state   <= WRITEBACK;
              mem_we  <= 1'b1;
              mem_adr <= {line_tag, index};
              mem_dat <= line_data;
            end else begin
              state   <= FILL;
              mem_we  <= 1'b0;
              mem_adr <= cpu_wishbone.adr;
            end
          end
        end
        WRITEBACK: begin
          if (mem_done) begin
            state   <= FILL;
            mem_we  <= 1'b0;
            mem_adr <= miss_adr;
          end
        end
        FILL: begin
          if (mem_done) begin
            state   <= IDLE;
            mem_cyc <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_cyc <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed and randomized checks of data_cache against a line-level model
module tb_data_cache;
  import lc3b_types::*;

  localparam int SETS = 8;
  localparam lc3b_cache_line K_LINE = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wishbone cpu_bus ();
  wishbone mem_bus ();

  data_cache #(.NUM_SETS(SETS)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_wishbone (cpu_bus),
    .mem_wishbone (mem_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: cache contents per set plus its own view of backing memory.
  logic           m_valid [SETS];
  logic           m_dirty [SETS];
  int             m_tag   [SETS];
  lc3b_cache_line m_data  [SETS];
  lc3b_cache_line ref_mem   [int];
  lc3b_cache_line slave_mem [int];

  typedef struct {
    logic [11:0]    adr;
    logic           we;
    logic [15:0]    sel;
    lc3b_cache_line dat;
  } mem_op_t;
  mem_op_t mem_log[$];

  int wait_cfg  = 0;
  int rty_cfg   = 0;
  int ack_count = 0;

  function automatic lc3b_cache_line init_line(input int adr);
    lc3b_cache_line l;
    for (int i = 0; i < 8; i++) l[16*i +: 16] = 16'((adr * 40503) ^ (i * 4369) ^ 23040);
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_access(input logic [11:0] adr, input logic we, input logic [15:0] sel,
                              input lc3b_cache_line wdat, output logic hit, output logic wb,
                              output logic [11:0] wb_adr, output lc3b_cache_line wb_dat,
                              output lc3b_cache_line rdat);
    int idx, tg;
    idx    = int'(adr) % SETS;
    tg     = int'(adr) / SETS;
    hit    = m_valid[idx] && (m_tag[idx] == tg);
    wb     = 1'b0;
    wb_adr = '0;
    wb_dat = '0;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        wb      = 1'b1;
        wb_adr  = 12'(m_tag[idx] * SETS + idx);
        wb_dat  = m_data[idx];
        ref_mem[int'(wb_adr)] = m_data[idx];
      end
      m_data[idx]  = ref_mem.exists(int'(adr)) ? ref_mem[int'(adr)] : init_line(int'(adr));
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    if (we) begin
      for (int i = 0; i < 16; i++) if (sel[i]) m_data[idx][8*i +: 8] = wdat[8*i +: 8];
      m_dirty[idx] = 1'b1;
    end
    rdat = m_data[idx];
  endtask

  // Memory slave: configurable wait states and one retry per access, checks held outputs.
  initial begin
    int      wait_left, rty_left, a;
    logic    in_access;
    logic [11:0] held_adr;
    logic    held_we;
    mem_op_t op;
    in_access = 1'b0;
    wait_left = 0;
    rty_left  = 0;
    held_adr  = '0;
    held_we   = 1'b0;
    mem_bus.ack   = 1'b0;
    mem_bus.rty   = 1'b0;
    mem_bus.dat_s = '0;
    forever begin
      @(negedge clk);
      mem_bus.ack = 1'b0;
      mem_bus.rty = 1'b0;
      if (mem_bus.cyc && mem_bus.stb) begin
        if (!in_access) begin
          in_access = 1'b1;
          wait_left = wait_cfg;
          rty_left  = rty_cfg;
          held_adr  = mem_bus.adr;
          held_we   = mem_bus.we;
        end else begin
          check("mem_adr_hold", 128'(mem_bus.adr), 128'(held_adr));
          check("mem_we_hold", 128'(mem_bus.we), 128'(held_we));
        end
        if (wait_left > 0) begin
          wait_left--;
        end else if (rty_left > 0) begin
          rty_left--;
          mem_bus.rty = 1'b1;
        end else begin
          in_access = 1'b0;
          a = int'(mem_bus.adr);
          if (mem_bus.we) slave_mem[a] = mem_bus.dat_m;
          else mem_bus.dat_s = slave_mem.exists(a) ? slave_mem[a] : init_line(a);
          op.adr = mem_bus.adr;
          op.we  = mem_bus.we;
          op.sel = mem_bus.sel;
          op.dat = mem_bus.we ? mem_bus.dat_m : mem_bus.dat_s;
          mem_log.push_back(op);
          mem_bus.ack = 1'b1;
        end
      end else begin
        in_access = 1'b0;
      end
    end
  end

  // CPU-side monitor: counts acknowledged requests and watches for illegal responses.
  initial begin
    forever begin
      @(negedge clk);
      check("cpu_ack_without_req", 128'(cpu_bus.ack & ~(cpu_bus.cyc & cpu_bus.stb)), 128'(0));
      check("cpu_rty_low", 128'(cpu_bus.rty), 128'(0));
      if (cpu_bus.ack && cpu_bus.cyc && cpu_bus.stb) ack_count++;
    end
  end

  task automatic drive_req(input logic [11:0] adr, input logic we, input logic [15:0] sel,
                           input lc3b_cache_line wdat);
    cpu_bus.cyc   = 1'b1;
    cpu_bus.stb   = 1'b1;
    cpu_bus.adr   = adr;
    cpu_bus.we    = we;
    cpu_bus.sel   = sel;
    cpu_bus.dat_m = wdat;
  endtask

  task automatic do_req(input logic [11:0] adr, input logic we, input logic [15:0] sel,
                        input lc3b_cache_line wdat, output lc3b_cache_line got_rd);
    logic           hit, wb, got;
    logic [11:0]    wb_adr;
    lc3b_cache_line wb_dat, exp_rd;
    int             acc, exp_lat, lat, acks0, exp_ops;
    acc = wait_cfg + rty_cfg + 1;
    model_access(adr, we, sel, wdat, hit, wb, wb_adr, wb_dat, exp_rd);
    exp_lat = hit ? 0 : (1 + acc + (wb ? acc : 0));
    exp_ops = hit ? 0 : (wb ? 2 : 1);
    mem_log.delete();
    acks0  = ack_count;
    got    = 1'b0;
    got_rd = '0;
    lat    = 0;
    @(posedge clk); #1;
    drive_req(adr, we, sel, wdat);
    while (!got && lat < 200) begin
      @(negedge clk);
      if (cpu_bus.ack) begin
        got    = 1'b1;
        got_rd = cpu_bus.dat_s;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("cpu_ack_seen", 128'(got), 128'(1));
    check("latency", 128'(lat), 128'(exp_lat));
    if (!we) check("read_data", got_rd, exp_rd);
    @(posedge clk); #1;
    cpu_bus.cyc = 1'b0;
    cpu_bus.stb = 1'b0;
    @(negedge clk);
    check("ack_once", 128'(ack_count - acks0), 128'(1));
    check("mem_ops", 128'(mem_log.size()), 128'(exp_ops));
    if (!hit && mem_log.size() == exp_ops) begin
      if (wb) begin
        check("wb_adr", 128'(mem_log[0].adr), 128'(wb_adr));
        check("wb_we", 128'(mem_log[0].we), 128'(1));
        check("wb_sel", 128'(mem_log[0].sel), 128'(16'hFFFF));
        check("wb_data", mem_log[0].dat, wb_dat);
      end
      check("fill_adr", 128'(mem_log[exp_ops-1].adr), 128'(adr));
      check("fill_we", 128'(mem_log[exp_ops-1].we), 128'(0));
      check("fill_sel", 128'(mem_log[exp_ops-1].sel), 128'(16'hFFFF));
    end
  endtask

  initial begin
    lc3b_cache_line rd, d_wb;
    logic           d_hit, d_w;
    logic [11:0]    d_adr;
    int             acks0;
    logic [11:0]    r_adr;

    cpu_bus.cyc   = 1'b0;
    cpu_bus.stb   = 1'b0;
    cpu_bus.we    = 1'b0;
    cpu_bus.adr   = '0;
    cpu_bus.sel   = '0;
    cpu_bus.dat_m = '0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_cpu_ack", 128'(cpu_bus.ack), 128'(0));
    check("reset_mem_cyc", 128'(mem_bus.cyc), 128'(0));
    check("reset_mem_stb", 128'(mem_bus.stb), 128'(0));
    check("reset_mem_we", 128'(mem_bus.we), 128'(0));

    // Cold read, then a zero-wait hit, then a byte-masked write hit.
    ref_mem[16]   = K_LINE;
    slave_mem[16] = K_LINE;
    do_req(12'h010, 1'b0, 16'h0000, '0, rd);
    check("fill_line_const", rd, K_LINE);
    do_req(12'h010, 1'b0, 16'h0000, '0, rd);
    do_req(12'h010, 1'b1, 16'h0003, {112'h0, 16'hBEEF}, rd);
    do_req(12'h010, 1'b0, 16'h0000, '0, rd);
    check("merged_line_const", rd, 128'h0123456789ABCDEF0123456789ABBEEF);

    // Conflict miss on a dirty line: writeback of the merged line, then fill.
    do_req(12'h110, 1'b0, 16'h0000, '0, rd);
    check("wb_mem_const", slave_mem[16], 128'h0123456789ABCDEF0123456789ABBEEF);

    // Slow slave with wait states and a retry during the fill.
    wait_cfg = 3;
    rty_cfg  = 1;
    do_req(12'h020, 1'b0, 16'h0000, '0, rd);
    wait_cfg = 0;
    rty_cfg  = 0;

    // Reset pulsed during a fill, coinciding with the slave's ack.
    wait_cfg = 1;
    mem_log.delete();
    @(posedge clk); #1;
    drive_req(12'h031, 1'b0, 16'h0000, '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fill_in_progress", 128'(mem_bus.cyc), 128'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset       = 1'b0;
    cpu_bus.cyc = 1'b0;
    cpu_bus.stb = 1'b0;
    @(negedge clk);
    check("abort_mem_cyc", 128'(mem_bus.cyc), 128'(0));
    model_reset();
    wait_cfg = 0;
    do_req(12'h031, 1'b0, 16'h0000, '0, rd);
    do_req(12'h010, 1'b0, 16'h0000, '0, rd);

    // Master walks away mid-fill: the fill completes silently and later hits.
    wait_cfg = 2;
    mem_log.delete();
    acks0 = ack_count;
    @(posedge clk); #1;
    drive_req(12'h042, 1'b0, 16'h0000, '0);
    @(posedge clk); #1;
    cpu_bus.cyc = 1'b0;
    cpu_bus.stb = 1'b0;
    repeat (8) @(negedge clk);
    check("drop_no_ack", 128'(ack_count - acks0), 128'(0));
    check("drop_mem_idle", 128'(mem_bus.cyc), 128'(0));
    check("drop_fill_ops", 128'(mem_log.size()), 128'(1));
    model_access(12'h042, 1'b0, 16'h0000, '0, d_hit, d_w, d_adr, d_wb, rd);
    wait_cfg = 0;
    do_req(12'h042, 1'b0, 16'h0000, '0, rd);

    // Randomized traffic over a few tags per set to force hits, conflicts and writebacks.
    for (int k = 0; k < 200; k++) begin
      wait_cfg = $urandom_range(0, 2);
      rty_cfg  = $urandom_range(0, 1);
      r_adr    = 12'($urandom_range(0, 3) * SETS + $urandom_range(0, SETS - 1));
      if ($urandom_range(0, 1) == 1)
        do_req(r_adr, 1'b1, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, rd);
      else
        do_req(r_adr, 1'b0, 16'($urandom), '0, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
